// File: rtl/spio_hss_multiplexer_rx_pkt_fifo.sv
// Receive packet buffer: FIFO_DEPTH storage + registered output stage, 1-cycle bypass when empty,
// drops (never stalls) input when full, cfcf hysteresis flag; SPIO_HSS_RX_PKT_FIFO_DROP_CNT_EN adds drop_cnt/drop_clr.
module spio_hss_multiplexer_rx_pkt_fifo #(
  parameter int PKT_BITS  = 72,
  parameter int FIFO_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PKT_BITS-1:0]    ipkt_data,
  input  logic                   ipkt_vld,
  output logic [PKT_BITS-1:0]    opkt_data,
  output logic                   opkt_vld,
  input  logic                   opkt_rdy,
  output logic                   cfcf,
  output logic                   drop,
  output logic [FIFO_BITS+1:0]   occ
`ifdef SPIO_HSS_RX_PKT_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt,
  input  logic                   drop_clr
`endif
);

  localparam int FIFO_DEPTH = 1 << FIFO_BITS;
  localparam int FB = FIFO_BITS;
  localparam int CW = FIFO_BITS + 1;
  localparam int OW = FIFO_BITS + 2;
  localparam logic [OW-1:0] CLR_TH = OW'(3 * FIFO_DEPTH / 4);
  localparam logic [OW-1:0] SET_TH = OW'(FIFO_DEPTH / 4);

  logic [PKT_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [FB-1:0]       rdp_q, rdp_d, wtp_q, wtp_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [OW-1:0]       occ_q, occ_d;
  logic [PKT_BITS-1:0] opkt_data_q, opkt_data_d;
  logic                opkt_vld_q, opkt_vld_d;
  logic                cfcf_q, cfcf_d;
  logic                drop_q, drop_d;

  logic consume, reg_free, full, accept, ld_store, bypass, wr_en;

  assign consume  = opkt_vld_q && opkt_rdy;
  assign reg_free = !opkt_vld_q || consume;
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  // A freeing output register pulls from storage, so a full buffer still has room this cycle.
  assign accept   = ipkt_vld && (!full || reg_free);
  assign ld_store = reg_free && (cnt_q != '0);
  assign bypass   = reg_free && (cnt_q == '0) && ipkt_vld;
  assign wr_en    = accept && !bypass;

  always_comb begin
    rdp_d       = ld_store ? rdp_q + FB'(1) : rdp_q;
    wtp_d       = wr_en ? wtp_q + FB'(1) : wtp_q;
    cnt_d       = cnt_q + CW'(wr_en) - CW'(ld_store);
    occ_d       = occ_q + OW'(accept) - OW'(consume);
    drop_d      = ipkt_vld && !accept;
    opkt_data_d = opkt_data_q;
    opkt_vld_d  = opkt_vld_q;
    if (ld_store) begin
      opkt_data_d = mem_q[rdp_q];
      opkt_vld_d  = 1'b1;
    end else if (bypass) begin
      opkt_data_d = ipkt_data;
      opkt_vld_d  = 1'b1;
    end else if (consume) begin
      opkt_vld_d  = 1'b0;
    end
    cfcf_d = cfcf_q;
    if (occ_d >= CLR_TH)      cfcf_d = 1'b0;
    else if (occ_d <= SET_TH) cfcf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdp_q       <= '0;
      wtp_q       <= '0;
      cnt_q       <= '0;
      occ_q       <= '0;
      opkt_data_q <= '0;
      opkt_vld_q  <= 1'b0;
      cfcf_q      <= 1'b1;
      drop_q      <= 1'b0;
    end else begin
      rdp_q       <= rdp_d;
      wtp_q       <= wtp_d;
      cnt_q       <= cnt_d;
      occ_q       <= occ_d;
      opkt_data_q <= opkt_data_d;
      opkt_vld_q  <= opkt_vld_d;
      cfcf_q      <= cfcf_d;
      drop_q      <= drop_d;
    end
  end

  // Storage array carries no reset; validity is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wtp_q] <= ipkt_data;
  end

  assign opkt_data = opkt_data_q;
  assign opkt_vld  = opkt_vld_q;
  assign cfcf      = cfcf_q;
  assign drop      = drop_q;
  assign occ       = occ_q;

`ifdef SPIO_HSS_RX_PKT_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_clr)                          drop_cnt_d = drop_d ? 16'd1 : 16'd0;
    else if (drop_d && drop_cnt_q != '1)   drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
